// File: rtl/ff_addsub_if.sv
// ============================================================================
//  Module  : ff_addsub_if
//  Brief   : Request/response bundle for the limb-serial modular add/sub unit.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ff_addsub_if #(
   parameter int WIDTH = 255
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             valid;

   modport master (output start, op, a, b, input busy, result, valid);
   modport slave  (input start, op, a, b, output busy, result, valid);
endinterface

`default_nettype wire

// File: rtl/ff_addsub.sv
// ============================================================================
//  Module  : ff_addsub
//  Brief   : Limb-serial (a +/- b) mod p; optional negate when FF_ADDSUB_NEG_EN
//            is defined (op = 1x gives (0 - a) mod p).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_addsub #(
   parameter int               WIDTH   = 255,
   parameter int               LIMB    = 64,
   parameter logic [WIDTH-1:0] MODULUS =
      WIDTH'(255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed)
) (
   input  wire logic  clk,
   input  wire logic  rst,
   ff_addsub_if.slave s_bus
);

   localparam int c_NL = (WIDTH + LIMB - 1) / LIMB;
   localparam int c_EW = c_NL * LIMB;
   localparam int c_CW = (c_NL > 1) ? $clog2(c_NL) : 1;
   localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_NL - 1);
   localparam logic [c_EW-1:0] c_P_EXT = c_EW'(MODULUS);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [c_CW-1:0]  r_cnt;
   logic [c_EW-1:0]  r_a;
   logic [c_EW-1:0]  r_b;
   logic [c_EW-1:0]  r_x;
   logic [c_EW-1:0]  r_y;
   logic             r_c1;
   logic             r_c2;
   logic             r_add;
   logic             r_pick;
   logic [WIDTH-1:0] r_result;
   logic             r_valid;

   logic             w_busy;
   logic             w_accept;
   logic             w_run;
   logic             w_last;
   logic             w_done;
   logic [WIDTH-1:0] w_cap_a;
   logic [WIDTH-1:0] w_cap_b;
   logic             w_cap_add;
   logic [LIMB-1:0]  w_al;
   logic [LIMB-1:0]  w_bl;
   logic [LIMB-1:0]  w_pl;
   logic [LIMB:0]    w_sum1;
   logic [LIMB:0]    w_sum2;
   logic             w_pick;
   logic [c_EW+LIMB-1:0] w_xcat;
   logic [c_EW+LIMB-1:0] w_ycat;

`ifdef FF_ADDSUB_NEG_EN
   logic w_neg;
   assign w_neg     = s_bus.op[1];
   assign w_cap_a   = w_neg ? '0 : s_bus.a;
   assign w_cap_b   = w_neg ? s_bus.a : s_bus.b;
   assign w_cap_add = ~w_neg & s_bus.op[0];
`else
   logic w_unused_op1;
   assign w_unused_op1 = s_bus.op[1];
   assign w_cap_a      = s_bus.a;
   assign w_cap_b      = s_bus.b;
   assign w_cap_add    = s_bus.op[0];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (s_bus.start) w_next = c_RUN;
         c_RUN:   if (r_cnt == c_LAST) w_next = c_DONE;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = (r_state != c_IDLE);
      w_accept = (r_state == c_IDLE) & s_bus.start;
      w_run    = (r_state == c_RUN);
      w_last   = w_run & (r_cnt == c_LAST);
      w_done   = (r_state == c_DONE);
   end

   // Primary chain is a-b (or a+b); the secondary chain corrects by +p (or -p).
   always_comb begin
      w_al = r_a[LIMB-1:0];
      w_bl = r_b[LIMB-1:0];
      w_pl = c_P_EXT[r_cnt*LIMB +: LIMB];
      if (r_add) begin
         w_sum1 = {1'b0, w_al} + {1'b0, w_bl} + {{LIMB{1'b0}}, r_c1};
         w_sum2 = {1'b0, w_sum1[LIMB-1:0]} - {1'b0, w_pl} - {{LIMB{1'b0}}, r_c2};
         w_pick = w_sum1[LIMB] | ~w_sum2[LIMB];
      end else begin
         w_sum1 = {1'b0, w_al} - {1'b0, w_bl} - {{LIMB{1'b0}}, r_c1};
         w_sum2 = {1'b0, w_sum1[LIMB-1:0]} + {1'b0, w_pl} + {{LIMB{1'b0}}, r_c2};
         w_pick = w_sum1[LIMB];
      end
      w_xcat = {w_sum1[LIMB-1:0], r_x} >> LIMB;
      w_ycat = {w_sum2[LIMB-1:0], r_y} >> LIMB;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_c1     <= 1'b0;
         r_c2     <= 1'b0;
         r_add    <= 1'b0;
         r_pick   <= 1'b0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_a   <= c_EW'(w_cap_a);
            r_b   <= c_EW'(w_cap_b);
            r_add <= w_cap_add;
            r_cnt <= '0;
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
         end else if (w_run) begin
            r_a   <= r_a >> LIMB;
            r_b   <= r_b >> LIMB;
            r_x   <= w_xcat[c_EW-1:0];
            r_y   <= w_ycat[c_EW-1:0];
            r_c1  <= w_sum1[LIMB];
            r_c2  <= w_sum2[LIMB];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_pick <= w_pick;
            end
         end
         if (w_done) begin
            r_result <= r_pick ? r_y[WIDTH-1:0] : r_x[WIDTH-1:0];
            r_valid  <= 1'b1;
         end
      end
   end

   assign s_bus.busy   = w_busy;
   assign s_bus.valid  = r_valid;
   assign s_bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ff_addsub.sv
// ============================================================================
//  Module  : tb_ff_addsub
//  Brief   : Directed self-checking bench for ff_addsub (default and 8-bit builds).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_addsub;

   localparam logic [254:0] P =
      255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   ff_addsub_if #(.WIDTH(255)) bus  ();
   ff_addsub_if #(.WIDTH(8))   bus8 ();

   ff_addsub u_dut (
      .clk   (clk),
      .rst   (rst),
      .s_bus (bus)
   );

   ff_addsub #(.WIDTH(8), .LIMB(3), .MODULUS(8'd251)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .s_bus (bus8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one request, scrambles inputs after capture, waits (bounded) for valid.
   task automatic run_op(input logic [1:0] op, input logic [254:0] a, input logic [254:0] b,
                         output logic [254:0] res, output int lat, output int busy_cyc);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = ~op;
      bus.a     = ~a;
      bus.b     = ~b;
      lat       = -1;
      busy_cyc  = bus.busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.valid) begin
            lat = k;
            break;
         end
         if (bus.busy) busy_cyc++;
      end
      res = bus.result;
   endtask

   task automatic run_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output int lat);
      bus8.start = 1'b1;
      bus8.op    = op;
      bus8.a     = a;
      bus8.b     = b;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.a     = ~a;
      bus8.b     = ~b;
      lat        = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus8.valid) begin
            lat = k;
            break;
         end
      end
      res = bus8.result;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #12;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (bus.valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
      end
      checks++;
      if (bus.result !== 255'd0) begin
         failures++; $display("FAIL reset_result: got %h expected 0", bus.result);
      end
      checks++;
      if (bus8.result !== 8'd0 || bus8.busy !== 1'b0) begin
         failures++; $display("FAIL reset_w8: got result %h busy %b expected 0 0", bus8.result, bus8.busy);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sub;
      logic [254:0] res;
      int lat, bc;
      run_op(2'b00, 255'd5, 255'd7, res, lat, bc);
      checks++;
      if (res !== P - 255'd2) begin
         failures++; $display("FAIL sub_5_7: got %h expected %h", res, P - 255'd2);
      end
      checks++;
      if (lat !== 5) begin
         failures++; $display("FAIL sub_latency: got %0d expected 5", lat);
      end
      checks++;
      if (bc !== 5) begin
         failures++; $display("FAIL sub_busy_cycles: got %0d expected 5", bc);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.valid !== 1'b0) begin
         failures++; $display("FAIL valid_single_cycle: got %b expected 0", bus.valid);
      end
      run_op(2'b00, 255'd1234, 255'd1234, res, lat, bc);
      checks++;
      if (res !== 255'd0) begin
         failures++; $display("FAIL sub_equal: got %h expected 0", res);
      end
   endtask

   task automatic test_add;
      logic [254:0] res;
      int lat, bc;
      run_op(2'b01, P - 255'd1, P - 255'd1, res, lat, bc);
      checks++;
      if (res !== P - 255'd2) begin
         failures++; $display("FAIL add_pm1_pm1: got %h expected %h", res, P - 255'd2);
      end
      run_op(2'b01, 255'd3, P - 255'd3, res, lat, bc);
      checks++;
      if (res !== 255'd0) begin
         failures++; $display("FAIL add_to_p: got %h expected 0", res);
      end
      run_op(2'b01, 255'd2, 255'd3, res, lat, bc);
      checks++;
      if (res !== 255'd5) begin
         failures++; $display("FAIL add_small: got %h expected 5", res);
      end
   endtask

   task automatic test_width8;
      logic [7:0] res;
      int lat;
      run_op8(2'b01, 8'd250, 8'd3, res, lat);
      checks++;
      if (res !== 8'd2) begin
         failures++; $display("FAIL w8_add: got %0d expected 2", res);
      end
      checks++;
      if (lat !== 4) begin
         failures++; $display("FAIL w8_latency: got %0d expected 4", lat);
      end
      run_op8(2'b00, 8'd3, 8'd250, res, lat);
      checks++;
      if (res !== 8'd4) begin
         failures++; $display("FAIL w8_sub: got %0d expected 4", res);
      end
   endtask

   task automatic test_back_to_back;
      int exp_res [4] = '{10, 22, 34, 46};
      int nval;
      nval = 0;
      for (int i = 0; i < 20; i++) begin
         bus.start = 1'b1;
         bus.op    = 2'b01;
         bus.a     = 255'(10 + i);
         bus.b     = 255'(i);
         @(posedge clk); #1;
         if (bus.valid) begin
            checks++;
            if (nval > 3 || bus.result !== 255'(exp_res[nval])) begin
               failures++; $display("FAIL b2b_result: got %0d at pulse %0d", bus.result, nval);
            end
            nval++;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (nval !== 3) begin
         failures++; $display("FAIL b2b_pulses: got %0d expected 3", nval);
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (bus.valid) begin
            nval++;
            break;
         end
      end
      checks++;
      if (nval !== 4 || bus.result !== 255'd46) begin
         failures++; $display("FAIL b2b_last: got pulses %0d result %0d expected 4 46", nval, bus.result);
      end
   endtask

   task automatic test_reset_mid;
      logic [254:0] res;
      int lat, bc, nval;
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.a     = 255'd5;
      bus.b     = 255'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (bus.valid !== 1'b0) begin
         failures++; $display("FAIL midrst_valid: got %b expected 0", bus.valid);
      end
      checks++;
      if (bus.result !== 255'd0) begin
         failures++; $display("FAIL midrst_result: got %h expected 0", bus.result);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      nval = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (bus.valid) nval++;
      end
      checks++;
      if (nval !== 0) begin
         failures++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", nval);
      end
      run_op(2'b00, 255'd9, 255'd4, res, lat, bc);
      checks++;
      if (res !== 255'd5 || lat !== 5) begin
         failures++; $display("FAIL midrst_recover: got %0d latency %0d expected 5 5", res, lat);
      end
   endtask

   task automatic test_negate;
      logic [254:0] res;
      int lat, bc;
`ifdef FF_ADDSUB_NEG_EN
      run_op(2'b10, 255'd1, 255'd123, res, lat, bc);
      checks++;
      if (res !== P - 255'd1) begin
         failures++; $display("FAIL neg_1: got %h expected %h", res, P - 255'd1);
      end
      run_op(2'b10, 255'd0, 255'd9, res, lat, bc);
      checks++;
      if (res !== 255'd0) begin
         failures++; $display("FAIL neg_0: got %h expected 0", res);
      end
`else
      run_op(2'b10, 255'd5, 255'd7, res, lat, bc);
      checks++;
      if (res !== P - 255'd2) begin
         failures++; $display("FAIL op10_as_sub: got %h expected %h", res, P - 255'd2);
      end
      run_op(2'b11, 255'd5, 255'd7, res, lat, bc);
      checks++;
      if (res !== 255'd12) begin
         failures++; $display("FAIL op11_as_add: got %h expected 12", res);
      end
`endif
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.a      = '0;
      bus.b      = '0;
      bus8.start = 1'b0;
      bus8.op    = 2'b00;
      bus8.a     = '0;
      bus8.b     = '0;
      test_reset();
      test_sub();
      test_add();
      test_width8();
      test_back_to_back();
      test_reset_mid();
      test_negate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ff_addsub.md
FF_ADDSUB -- requirements
Module: ff_addsub

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 255, SHALL set the operand/result width in bits.
REQ-003 Parameter LIMB, default 64, SHALL set the bits processed per cycle (1 <= LIMB <= WIDTH).
REQ-004 Parameter MODULUS, default 2^255-19, WIDTH bits, SHALL set the field prime p.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request; sampled only when busy is low.
REQ-008 op  input  2  00 = subtract, 01 = add, 1x = negate (see Configuration).
REQ-009 a  input  WIDTH  first operand, canonical (< p).
REQ-010 b  input  WIDTH  second operand, canonical (< p).
REQ-011 busy  output  1  high from the cycle after start is accepted until valid has pulsed.
REQ-012 result  output  WIDTH  (a op b) mod p, held until the next completion.
REQ-013 valid  output  1  single-cycle completion strobe.

Function
REQ-014 NL SHALL equal ceil(WIDTH/LIMB); the top limb SHALL be zero-extended.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after NL limb cycles; DONE->IDLE unconditionally.
REQ-016 On start in IDLE, a, b and op SHALL be captured; later input changes SHALL not affect the operation.
REQ-017 Subtract: d = a - b limb-serial with a borrow chain; in parallel, d + p; result = d + p if final borrow, else d.
REQ-018 Add: s = a + b with a carry chain; in parallel, t = s - p; result = t if carry-out or t has no borrow, else s.
REQ-019 Both chains SHALL advance one limb per RUN cycle; the select SHALL occur on the RUN->DONE edge.
REQ-020 valid SHALL be high for exactly one cycle, beginning at the (NL+1)th rising edge after the edge that samples start.
REQ-021 result SHALL update only on the edge that raises valid.
REQ-022 start asserted while busy is high SHALL be ignored, with no queuing.
REQ-023 Back-to-back operation: start in the cycle after valid SHALL be accepted, giving a throughput of one operation per NL+2 cycles.
REQ-024 A zero result SHALL always be encoded as 0, never as p.
REQ-025 For non-canonical inputs, result SHALL follow REQ-017 and REQ-018 literally, with no error flag.

Reset
REQ-026 While rst is low, the FSM SHALL be IDLE, and busy, valid and result SHALL be 0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no valid pulse SHALL follow.
REQ-028 start SHALL be ignored on the first edge at which rst is high only if rst deasserted within setup time; otherwise it is accepted normally.

Configuration
REQ-029 Macro FF_ADDSUB_NEG_EN defined: op = 1x SHALL compute (0 - a) mod p via the subtract path with the minuend forced to 0 and b ignored; neg 0 = 0.
REQ-030 Macro FF_ADDSUB_NEG_EN undefined: op[1] SHALL be ignored, op = 1x SHALL behave as op[0], and the negate logic SHALL not be synthesised.

Verification
REQ-031 Default parameters, sub a=5, b=7 -> result = 2^255-21, valid exactly 5 cycles after the start edge, busy high for 5 cycles.
REQ-032 Default parameters, add a=b=2^255-20 (p-1) -> result = 2^255-21; add a=3, b=p-3 -> result = 0.
REQ-033 WIDTH=8, LIMB=3, MODULUS=251: add 250+3 -> 2; sub 3-250 -> 4; valid 4 cycles after start.
REQ-034 start pulsed each cycle for 20 cycles -> exactly 3 valid pulses (default parameters), each result matching its captured operands.
REQ-035 rst pulled low in the 2nd RUN cycle -> busy, valid and result read 0 immediately; no valid pulse follows; the next start completes correctly.
REQ-036 With FF_ADDSUB_NEG_EN: neg a=1 -> p-1; neg a=0 -> 0. Without the macro: op=10 with a=5, b=7 -> p-2.
